// File: rtl/xor_frame_checksum.sv
// Folds a frame of WIDTH-bit words into a running XOR checksum (LRC), optionally checking for a zero residue.
// Latency: cks_vld pulses in the cycle after the edge that accepted the last (or MAX_LEN-th) word.
// Backpressure: din_rdy drops only for the single DONE cycle, giving one bubble per frame.
module xor_frame_checksum #(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 16,
  localparam int CW     = $clog2(MAX_LEN + 1)
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             chk_mode,
  input  logic             din_vld,
  output logic             din_rdy,
  input  logic [WIDTH-1:0] din,
  input  logic             din_last,
  output logic             cks_vld,
  output logic [WIDTH-1:0] cks,
  output logic             cks_ok,
  output logic [CW-1:0]    len,
  output logic             len_err,
  output logic             busy
);

  localparam logic [CW-1:0] MAX_LEN_C = CW'(MAX_LEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] cks_q, cks_d;
  logic [CW-1:0]    len_q, len_d;
  logic             cks_ok_q, cks_ok_d;
  logic             len_err_q, len_err_d;

  logic             accept;
  logic [WIDTH-1:0] acc_xor;
  logic [CW-1:0]    cnt_inc;
  logic             forced_end;

  assign accept     = din_vld & din_rdy;
  assign acc_xor    = acc_q ^ din;
  assign cnt_inc    = cnt_q + CW'(1);
  // cnt never exceeds MAX_LEN, so this compare is what keeps it from wrapping
  assign forced_end = (cnt_inc == MAX_LEN_C);

  // State and datapath registers; reset discards any partial frame and clears results
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      cks_q     <= '0;
      len_q     <= '0;
      cks_ok_q  <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      cks_q     <= cks_d;
      len_q     <= len_d;
      cks_ok_q  <= cks_ok_d;
      len_err_q <= len_err_d;
    end
  end

  // Next-state and result capture; results load on entry to DONE and hold until the next frame ends
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    cks_d     = cks_q;
    len_d     = len_q;
    cks_ok_d  = cks_ok_q;
    len_err_d = len_err_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d  = din;
          cnt_d  = CW'(1);
          mode_d = chk_mode;
          if (din_last) begin
            // mode_q is only being loaded now, so the live chk_mode decides cks_ok
            state_d   = DONE;
            cks_d     = din;
            len_d     = CW'(1);
            cks_ok_d  = chk_mode & (din == '0);
            len_err_d = 1'b0;
          end else begin
            state_d = ACC;
          end
        end
      end
      ACC: begin
        if (accept) begin
          acc_d = acc_xor;
          cnt_d = cnt_inc;
          if (din_last || forced_end) begin
            state_d   = DONE;
            cks_d     = acc_xor;
            len_d     = cnt_inc;
            cks_ok_d  = mode_q & (acc_xor == '0);
            len_err_d = forced_end & ~din_last;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign din_rdy = (state_q != DONE);
  assign busy    = (state_q == ACC);
  assign cks_vld = (state_q == DONE);
  assign cks     = cks_q;
  assign len     = len_q;
  assign cks_ok  = cks_ok_q;
  assign len_err = len_err_q;

endmodule

// File: tb/tb_xor_frame_checksum.sv
module tb_xor_frame_checksum;

  localparam int WIDTH   = 8;
  localparam int MAX_LEN = 16;
  localparam int CW      = $clog2(MAX_LEN + 1);

  logic             sys_clk;
  logic             sys_rst_n;
  logic             chk_mode;
  logic             din_vld;
  logic             din_rdy;
  logic [WIDTH-1:0] din;
  logic             din_last;
  logic             cks_vld;
  logic [WIDTH-1:0] cks;
  logic             cks_ok;
  logic [CW-1:0]    len;
  logic             len_err;
  logic             busy;

  int n_checks;
  int n_errors;

  xor_frame_checksum #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .chk_mode  (chk_mode),
    .din_vld   (din_vld),
    .din_rdy   (din_rdy),
    .din       (din),
    .din_last  (din_last),
    .cks_vld   (cks_vld),
    .cks       (cks),
    .cks_ok    (cks_ok),
    .len       (len),
    .len_err   (len_err),
    .busy      (busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // one comparison: count it, report a mismatch
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // present one word from the falling edge; the next rising edge may accept it
  task automatic send(input logic [7:0] d, input logic last, input logic mode);
    @(negedge sys_clk);
    din_vld  = 1'b1;
    din      = d;
    din_last = last;
    chk_mode = mode;
  endtask

  task automatic idle_cycle();
    @(negedge sys_clk);
    din_vld  = 1'b0;
    din_last = 1'b0;
  endtask

  // one cycle after the last word: result pulse with expected contents, then back to idle
  task automatic expect_result(input string tag, input logic [7:0] e_cks, input int e_len,
                               input logic e_ok, input logic e_err);
    idle_cycle();
    check({tag, ".vld"}, 32'(cks_vld), 32'd1);
    check({tag, ".cks"}, 32'(cks), 32'(e_cks));
    check({tag, ".len"}, 32'(len), 32'(e_len));
    check({tag, ".ok"},  32'(cks_ok), 32'(e_ok));
    check({tag, ".err"}, 32'(len_err), 32'(e_err));
    check({tag, ".rdy"}, 32'(din_rdy), 32'd0);
    idle_cycle();
    check({tag, ".vld_end"}, 32'(cks_vld), 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    sys_rst_n = 1'b0;
    chk_mode  = 1'b0;
    din_vld   = 1'b0;
    din       = '0;
    din_last  = 1'b0;

    // reset state
    #12;
    check("rst.cks", 32'(cks), 32'd0);
    check("rst.len", 32'(len), 32'd0);
    check("rst.vld", 32'(cks_vld), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.rdy", 32'(din_rdy), 32'd1);
    check("rst.ok_err", {cks_ok, len_err}, 32'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // din_last without din_vld is ignored
    @(negedge sys_clk);
    din_last = 1'b1;
    idle_cycle();
    check("lastnovld.vld", 32'(cks_vld), 32'd0);
    check("lastnovld.busy", 32'(busy), 32'd0);

    // 1: generate mode
    send(8'h12, 1'b0, 1'b0);
    send(8'h34, 1'b0, 1'b0);
    check("t1.busy", 32'(busy), 32'd1);
    send(8'h56, 1'b1, 1'b0);
    expect_result("t1", 8'h70, 3, 1'b0, 1'b0);

    // 2: check mode; mode drop after first word is ignored
    send(8'h12, 1'b0, 1'b1);
    send(8'h34, 1'b0, 1'b0);
    send(8'h56, 1'b0, 1'b0);
    send(8'h70, 1'b1, 1'b0);
    expect_result("t2ok", 8'h00, 4, 1'b1, 1'b0);
    send(8'h12, 1'b0, 1'b1);
    send(8'h34, 1'b0, 1'b1);
    send(8'h56, 1'b0, 1'b1);
    send(8'h71, 1'b1, 1'b1);
    expect_result("t2bad", 8'h01, 4, 1'b0, 1'b0);

    // 3: forced end at MAX_LEN, then last on the MAX_LEN-th word
    for (int i = 0; i < MAX_LEN; i++) send(8'h01, 1'b0, 1'b0);
    expect_result("t3forced", 8'h00, 16, 1'b0, 1'b1);
    for (int i = 0; i < MAX_LEN; i++) send(8'h01, (i == MAX_LEN - 1), 1'b0);
    expect_result("t3last", 8'h00, 16, 1'b0, 1'b0);

    // 4: gaps inside a frame; a word offered during DONE is refused
    send(8'hAA, 1'b0, 1'b0);
    idle_cycle();
    idle_cycle();
    idle_cycle();
    check("t4.gapbusy", 32'(busy), 32'd1);
    send(8'h55, 1'b1, 1'b0);
    send(8'h99, 1'b1, 1'b0);
    check("t4.vld", 32'(cks_vld), 32'd1);
    check("t4.cks", 32'(cks), 32'hFF);
    check("t4.len", 32'(len), 32'd2);
    check("t4.rdy", 32'(din_rdy), 32'd0);
    idle_cycle();
    check("t4.refused", 32'(cks_vld), 32'd0);
    check("t4.refbusy", 32'(busy), 32'd0);
    check("t4.hold", 32'(cks), 32'hFF);

    // 5: back-to-back single-word frames
    send(8'h0F, 1'b1, 1'b0);
    send(8'hF0, 1'b1, 1'b0);
    check("t5a.vld", 32'(cks_vld), 32'd1);
    check("t5a.cks", 32'(cks), 32'h0F);
    @(negedge sys_clk);
    check("t5.gap", 32'(cks_vld), 32'd0);
    @(negedge sys_clk);
    check("t5b.vld", 32'(cks_vld), 32'd1);
    check("t5b.cks", 32'(cks), 32'hF0);
    check("t5b.len", 32'(len), 32'd1);
    idle_cycle();

    // 6: reset mid-frame
    send(8'h11, 1'b0, 1'b0);
    send(8'h22, 1'b0, 1'b0);
    @(negedge sys_clk);
    din_vld   = 1'b0;
    sys_rst_n = 1'b0;
    #1;
    check("t6.busy", 32'(busy), 32'd0);
    check("t6.cks", 32'(cks), 32'd0);
    check("t6.len", 32'(len), 32'd0);
    check("t6.vld", 32'(cks_vld), 32'd0);
    check("t6.rdy", 32'(din_rdy), 32'd1);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    idle_cycle();
    check("t6.novld", 32'(cks_vld), 32'd0);
    send(8'h3C, 1'b1, 1'b0);
    expect_result("t6new", 8'h3C, 1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
